// File: rtl/rv32im_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : rv32im_muldiv
// Purpose  : Iterative RV32M multiply/divide unit, one radix-2 step per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rv32im_muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] operand_a_i,
    input  logic [DATA_WIDTH-1:0] operand_b_i,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  busy_o
);

    localparam int                    c_CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0]    c_CNT_LAST = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0]    c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [DATA_WIDTH-1:0] c_MIN      = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [2:0]              r_op;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0]   r_hi;
    logic [DATA_WIDTH-1:0]   r_lo;
    logic [DATA_WIDTH-1:0]   r_b;
    logic                    r_neg_q;
    logic                    r_neg_r;
    logic [DATA_WIDTH-1:0]   r_result;

    // Request decode: operand signedness, magnitudes and fast-path detection
    logic                    w_accept;
    logic                    w_a_signed;
    logic                    w_b_signed;
    logic                    w_a_neg;
    logic                    w_b_neg;
    logic [DATA_WIDTH-1:0]   w_a_mag;
    logic [DATA_WIDTH-1:0]   w_b_mag;
    logic                    w_div_zero;
    logic                    w_overflow;
    logic                    w_fast;
    logic [DATA_WIDTH-1:0]   w_fast_result;
    logic                    w_last;

    assign w_accept   = valid_i && ready_o && !flush_i;
    assign w_a_signed = op_i[2] ? !op_i[0] : (op_i[1:0] == 2'b01 || op_i[1:0] == 2'b10);
    assign w_b_signed = op_i[2] ? !op_i[0] : (op_i[1:0] == 2'b01);
    assign w_a_neg    = w_a_signed && operand_a_i[DATA_WIDTH-1];
    assign w_b_neg    = w_b_signed && operand_b_i[DATA_WIDTH-1];
    assign w_a_mag    = w_a_neg ? -operand_a_i : operand_a_i;
    assign w_b_mag    = w_b_neg ? -operand_b_i : operand_b_i;
    assign w_div_zero = op_i[2] && (operand_b_i == '0);
    assign w_overflow = op_i[2] && !op_i[0] && (operand_a_i == c_MIN) && (operand_b_i == '1);
    assign w_fast     = w_div_zero || w_overflow;
    assign w_last     = (r_cnt == c_CNT_LAST);

    always_comb begin
        w_fast_result = '0;
        if (w_div_zero) begin
            w_fast_result = op_i[1] ? operand_a_i : '1;
        end else if (w_overflow) begin
            w_fast_result = op_i[1] ? '0 : operand_a_i;
        end
    end

    // Multiply: {hi,lo} shifts right, lo starts as the multiplier magnitude
    logic [DATA_WIDTH:0]     w_mul_sum;
    logic [DATA_WIDTH-1:0]   w_mul_hi;
    logic [DATA_WIDTH-1:0]   w_mul_lo;
    // Divide: hi is the partial remainder, lo shifts dividend out / quotient in
    logic [DATA_WIDTH:0]     w_shift;
    logic [DATA_WIDTH:0]     w_diff;
    logic                    w_ge;
    logic [DATA_WIDTH-1:0]   w_div_hi;
    logic [DATA_WIDTH-1:0]   w_div_lo;
    logic [DATA_WIDTH-1:0]   w_it_hi;
    logic [DATA_WIDTH-1:0]   w_it_lo;

    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_mul_hi  = w_mul_sum[DATA_WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[DATA_WIDTH-1:1]};
    assign w_shift   = {r_hi, r_lo[DATA_WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_b};
    assign w_ge      = !w_diff[DATA_WIDTH];
    assign w_div_hi  = w_ge ? w_diff[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
    assign w_div_lo  = {r_lo[DATA_WIDTH-2:0], w_ge};
    assign w_it_hi   = r_op[2] ? w_div_hi : w_mul_hi;
    assign w_it_lo   = r_op[2] ? w_div_lo : w_mul_lo;

    // Sign fix-up applied to the outcome of the final iteration
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [2*DATA_WIDTH-1:0] w_prod_s;
    logic [DATA_WIDTH-1:0]   w_quo;
    logic [DATA_WIDTH-1:0]   w_rem;
    logic [DATA_WIDTH-1:0]   w_final;

    assign w_prod   = {w_it_hi, w_it_lo};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quo    = r_neg_q ? -w_it_lo : w_it_lo;
    assign w_rem    = r_neg_r ? -w_it_hi : w_it_hi;

    always_comb begin
        w_final = '0;
        case (r_op)
            3'b000:                 w_final = w_prod_s[DATA_WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
            3'b100, 3'b101:         w_final = w_quo;
            default:                w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush_i) begin
            w_state_next = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  if (w_accept) w_state_next = w_fast ? c_DONE : c_BUSY;
                c_BUSY:  if (w_last) w_state_next = c_DONE;
                c_DONE:  if (result_ready_i) w_state_next = c_IDLE;
                default: w_state_next = c_IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o        = (r_state == c_IDLE);
        busy_o         = (r_state != c_IDLE);
        result_valid_o = (r_state == c_DONE);
        result_o       = result_valid_o ? r_result : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op     <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (!flush_i) begin
            if (r_state == c_IDLE && w_accept) begin
                r_op     <= op_i;
                r_cnt    <= '0;
                r_hi     <= '0;
                r_lo     <= w_a_mag;
                r_b      <= w_b_mag;
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
                r_result <= w_fast_result;
            end else if (r_state == c_BUSY) begin
                r_hi  <= w_it_hi;
                r_lo  <= w_it_lo;
                r_cnt <= r_cnt + c_CNT_ONE;
                if (w_last) begin
                    r_result <= w_final;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32im_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32im_muldiv
// Purpose  : Directed and reference-model checks for rv32im_muldiv.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32im_muldiv;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  op_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [31:0] result_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv32im_muldiv #(.DATA_WIDTH(32)) u_dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .op_i           (op_i),
        .operand_a_i    (operand_a_i),
        .operand_b_i    (operand_b_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_o       (result_o),
        .busy_o         (busy_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'h0, b}; return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one request, check latency and value, then consume the result
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        cyc = 0;
        while (!ready_o && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        check_eq({tag, "_ready"}, {31'h0, ready_o}, 32'h1);
        valid_i = 1'b1; op_i = op; operand_a_i = a; operand_b_i = b;
        @(posedge clk); #1;
        valid_i = 1'b0; op_i = 3'($urandom); operand_a_i = $urandom; operand_b_i = $urandom;
        cyc = 1;
        while (!result_valid_o && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        check_eq({tag, "_latency"}, 32'(cyc), 32'(lat));
        check_eq({tag, "_result"}, result_o, exp);
        result_ready_i = 1'b1;
        @(posedge clk); #1;
        result_ready_i = 1'b0;
        check_eq({tag, "_after_consume"}, {29'h0, result_valid_o, ready_o, busy_o}, 32'h2);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        valid_i = 1'b1; op_i = op; operand_a_i = a; operand_b_i = b;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    initial begin
        int pulses;
        int cyc;
        logic [31:0] corner [4];
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h8000_0000;
        rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; op_i = 3'd0;
        operand_a_i = '0; operand_b_i = '0; result_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", {29'h0, result_valid_o, busy_o, |result_o}, 32'h0);
        rst_i = 1'b0;
        @(posedge clk); #1;
        check_eq("ready_after_reset", {31'h0, ready_o}, 32'h1);

        do_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        do_op("mul_ff",   3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        do_op("mulhsu_ff",3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        do_op("mulh_ff",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        do_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        do_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        do_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 33);
        do_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 33);
        do_op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        do_op("rem_by0",  3'd6, 32'd5, 32'd0, 32'd5, 1);
        do_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        do_op("mulh_neg", 3'd1, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        do_op("div_pos_neg", 3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        do_op("rem_pos_neg", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);

        // Backpressure: result held, requests ignored, no accept on consume cycle
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cyc = 1;
        while (!result_valid_o && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        check_eq("bp_first_result", result_o, 32'hFFFF_FFFE);
        for (int i = 0; i < 10; i++) begin
            valid_i = i[0]; op_i = 3'd0; operand_a_i = 32'd3; operand_b_i = 32'd4;
            @(posedge clk); #1;
            check_eq("bp_hold_valid", {31'h0, result_valid_o}, 32'h1);
            check_eq("bp_hold_result", result_o, 32'hFFFF_FFFE);
            check_eq("bp_hold_ready", {31'h0, ready_o}, 32'h0);
        end
        valid_i = 1'b1; result_ready_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; result_ready_i = 1'b0;
        check_eq("bp_no_accept_on_consume", {30'h0, busy_o, ready_o}, 32'h1);

        // Flush on BUSY cycle 10
        issue(3'd5, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        check_eq("flush_busy_before", {31'h0, busy_o}, 32'h1);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check_eq("flush_to_idle", {29'h0, result_valid_o, busy_o, ready_o}, 32'h1);
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (result_valid_o) pulses++;
        end
        check_eq("flush_no_result", 32'(pulses), 32'h0);
        do_op("after_flush", 3'd7, 32'd100, 32'd7, 32'd2, 33);

        // Flush has priority over result_ready in DONE
        issue(3'd5, 32'd9, 32'd0);
        flush_i = 1'b1; result_ready_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0; result_ready_i = 1'b0;
        check_eq("flush_in_done", {29'h0, result_valid_o, busy_o, |result_o}, 32'h0);

        // Reset on BUSY cycle 5
        issue(3'd4, 32'd1000, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        check_eq("rst_mid_busy", {29'h0, result_valid_o, busy_o, |result_o}, 32'h0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (result_valid_o) pulses++;
        end
        check_eq("rst_no_result", 32'(pulses), 32'h0);

        // Back-to-back operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            rb  = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            if (i % 8 == 0) rb = 32'h0;
            do_op("rand", rop, ra, rb, ref_model(rop, ra, rb), exp_latency(rop, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32im_muldiv.md
RV32IM_MULDIV -- requirements
Module: rv32im_muldiv

Interface
REQ-001 The block SHALL have one parameter, DATA_WIDTH, default 32, setting the operand and result width (even, >=8).
REQ-002 The block SHALL have one clock, clk_i; reset rst_i is synchronous and active-high.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 flush_i  input  1  abort the in-flight operation and discard any pending result.
REQ-006 valid_i  input  1  request valid.
REQ-007 ready_o  output  1  unit can accept a request.
REQ-008 op_i  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-009 operand_a_i  input  DATA_WIDTH  rs1 value / dividend.
REQ-010 operand_b_i  input  DATA_WIDTH  rs2 value / divisor.
REQ-011 result_valid_o  output  1  result_o holds a completed result.
REQ-012 result_ready_i  input  1  consumer takes the result.
REQ-013 result_o  output  DATA_WIDTH  operation result.
REQ-014 busy_o  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-016 ready_o SHALL be 1 only in IDLE, and a request SHALL be accepted on a cycle with valid_i && ready_o && !flush_i.
REQ-017 On accept, op_i and both operands SHALL be latched; later input changes SHALL not affect the result.
REQ-018 Normal path: IDLE -> BUSY, one radix-2 iteration per cycle for exactly DATA_WIDTH cycles, then DONE; result_valid_o SHALL first be high DATA_WIDTH+1 cycles after the accept cycle.
REQ-019 Multiply SHALL form the full 2*DATA_WIDTH product: MUL returns the low half; MULH returns the high half (signed x signed); MULHSU the high half (signed a x unsigned b); MULHU the high half (unsigned x unsigned).
REQ-020 Divide SHALL be restoring division on magnitudes, with signs fixed up after the last iteration; the quotient SHALL round toward zero and the remainder SHALL take the sign of the dividend.
REQ-021 Divide by zero (b==0) SHALL take a fast path, IDLE -> DONE, with result_valid_o high one cycle after accept: DIV/DIVU return all ones, REM/REMU return operand_a.
REQ-022 Signed overflow (DIV/REM, a = most negative value, b = all ones) SHALL take the fast path: DIV returns a, REM returns 0.
REQ-023 In DONE, result_valid_o=1 and result_o SHALL be held stable until result_ready_i=1; that cycle SHALL return the FSM to IDLE.
REQ-024 A new request SHALL NOT be accepted in the cycle a result is consumed; ready_o rises the following cycle.
REQ-025 flush_i=1 in any state SHALL force IDLE next cycle and drop result_valid_o; flush_i SHALL take priority over accept and over result_ready_i.
REQ-026 result_o SHALL be 0 whenever result_valid_o=0.
REQ-027 An undefined or X op_i SHALL not occur by construction; all eight encodings are legal.

Reset
REQ-028 With rst_i=1 at a clock edge, the state SHALL become IDLE, all internal registers SHALL be 0, result_valid_o=0, result_o=0 and busy_o=0; ready_o=1 from the first cycle after reset is released.
REQ-029 Reset asserted mid-BUSY or in DONE SHALL abandon the operation; no result SHALL appear after reset.

Verification (DATA_WIDTH=32)
REQ-030 MULHU a=0xFFFFFFFF b=0xFFFFFFFF -> result 0xFFFFFFFE exactly 33 cycles after accept; MUL with the same operands -> 0x00000001; MULHSU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFF; MULH a=0xFFFFFFFF b=0xFFFFFFFF -> 0x00000000.
REQ-031 DIV a=-7 (0xFFFFFFF9) b=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU a=100 b=7 -> 14; REMU a=100 b=7 -> 2.
REQ-032 DIVU a=5 b=0 -> 0xFFFFFFFF one cycle after accept; REM a=5 b=0 -> 5; DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-033 Backpressure: hold result_ready_i=0 for 10 cycles in DONE -> result_valid_o stays 1 and result_o stays stable; ready_o=0 throughout; valid_i pulses in that window are ignored.
REQ-034 Assert flush_i on BUSY cycle 10 -> IDLE next cycle, no result_valid_o pulse; the next request completes correctly.
REQ-035 Assert rst_i on BUSY cycle 5 -> all outputs at reset values next cycle; random back-to-back ops are checked against a reference model, including operands 0, 1, all ones and the most negative value.
